// File: rtl/accel_issue_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : accel_issue_queue                                             |
// | Purpose  : In-order command FIFO and single-outstanding issue sequencer  |
// |            for the HE accelerator; absorbs SET_PARAM ops locally into    |
// |            the t/q modulus registers.                                    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module accel_issue_queue #(
  parameter int DEPTH     = 4,
  parameter int ADDR_W    = 32,
  parameter int BIT_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [2:0]               cmd_funct3,
  input  logic [ADDR_W-1:0]        cmd_src,
  input  logic [ADDR_W-1:0]        cmd_dst,
  output logic                     iq_assert,
  output logic [2:0]               funct3,
  output logic [ADDR_W-1:0]        source,
  output logic [ADDR_W-1:0]        destination,
  input  logic                     accel_ready,
  input  logic                     accel_done,
  output logic                     cmp_valid,
  output logic [ADDR_W-1:0]        cmp_dst,
  output logic [BIT_WIDTH-1:0]     he_t,
  output logic [BIT_WIDTH-1:0]     he_q,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err_spurious
);

  localparam int         PTR_W       = $clog2(DEPTH);
  localparam int         CNT_W       = PTR_W + 1;
  localparam logic [2:0] C_SET_PARAM = 3'b111;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  // Queue storage (data only; validity is tracked by the pointers/count)
  logic [2:0]        r_mem_f3  [DEPTH];
  logic [ADDR_W-1:0] r_mem_src [DEPTH];
  logic [ADDR_W-1:0] r_mem_dst [DEPTH];

  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  state_t            r_state;
  state_t            w_state_nxt;

  logic              r_iq_assert;
  logic [2:0]        r_funct3;
  logic [ADDR_W-1:0] r_source;
  logic [ADDR_W-1:0] r_destination;
  logic              r_cmp_valid;
  logic [ADDR_W-1:0] r_cmp_dst;
  logic [BIT_WIDTH-1:0] r_he_t;
  logic [BIT_WIDTH-1:0] r_he_q;
  logic              r_err;

  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_issue;
  logic              w_set;
  logic              w_cmp;
  logic              w_spur;
  logic [2:0]        w_head_f3;
  logic [ADDR_W-1:0] w_head_src;
  logic [ADDR_W-1:0] w_head_dst;

  // Full is judged on the registered count only, so a same-cycle pop never frees a slot
  assign w_full     = (r_count == CNT_W'(DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_push     = cmd_valid && !w_full;
  assign w_head_f3  = r_mem_f3[r_rd_ptr];
  assign w_head_src = r_mem_src[r_rd_ptr];
  assign w_head_dst = r_mem_dst[r_rd_ptr];

  // Write the incoming op at the tail
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_f3[r_wr_ptr]  <= cmd_funct3;
      r_mem_src[r_wr_ptr] <= cmd_src;
      r_mem_dst[r_wr_ptr] <= cmd_dst;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sequencer state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Sequencer decisions: SET_PARAM drains locally, accel ops wait for ready, BUSY waits for done
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_issue     = 1'b0;
    w_set       = 1'b0;
    w_cmp       = 1'b0;
    w_spur      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_spur = accel_done;
        if (!w_empty) begin
          if (w_head_f3 == C_SET_PARAM) begin
            w_pop = 1'b1;
            w_set = 1'b1;
          end else if (accel_ready) begin
            w_pop       = 1'b1;
            w_issue     = 1'b1;
            w_state_nxt = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (accel_done) begin
          w_cmp       = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Registered issue/completion/parameter outputs; issued fields hold until the next issue
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_iq_assert   <= 1'b0;
      r_funct3      <= '0;
      r_source      <= '0;
      r_destination <= '0;
      r_cmp_valid   <= 1'b0;
      r_cmp_dst     <= '0;
      r_he_t        <= '0;
      r_he_q        <= '0;
      r_err         <= 1'b0;
    end else begin
      r_iq_assert <= w_issue;
      r_cmp_valid <= w_cmp;
      if (w_issue) begin
        r_funct3      <= w_head_f3;
        r_source      <= w_head_src;
        r_destination <= w_head_dst;
      end
      if (w_cmp) r_cmp_dst <= r_destination;
      if (w_set) begin
        r_he_t <= w_head_src[BIT_WIDTH-1:0];
        r_he_q <= w_head_dst[BIT_WIDTH-1:0];
      end
      if (w_spur) r_err <= 1'b1;
    end
  end

  assign cmd_ready    = !w_full;
  assign iq_assert    = r_iq_assert;
  assign funct3       = r_funct3;
  assign source       = r_source;
  assign destination  = r_destination;
  assign cmp_valid    = r_cmp_valid;
  assign cmp_dst      = r_cmp_dst;
  assign he_t         = r_he_t;
  assign he_q         = r_he_q;
  assign count        = r_count;
  assign err_spurious = r_err;

endmodule
`default_nettype wire

// File: tb/tb_accel_issue_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_accel_issue_queue                                          |
// | Purpose  : Scenario-driven self-checking bench for accel_issue_queue     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_accel_issue_queue;

  localparam int DEPTH     = 4;
  localparam int ADDR_W    = 32;
  localparam int BIT_WIDTH = 32;

  typedef struct packed {
    logic [2:0]        f3;
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
  } op_t;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  cmd_valid = 1'b0;
  logic                  cmd_ready;
  logic [2:0]            cmd_funct3 = '0;
  logic [ADDR_W-1:0]     cmd_src = '0;
  logic [ADDR_W-1:0]     cmd_dst = '0;
  logic                  iq_assert;
  logic [2:0]            funct3;
  logic [ADDR_W-1:0]     source;
  logic [ADDR_W-1:0]     destination;
  logic                  accel_ready = 1'b0;
  logic                  accel_done = 1'b0;
  logic                  cmp_valid;
  logic [ADDR_W-1:0]     cmp_dst;
  logic [BIT_WIDTH-1:0]  he_t;
  logic [BIT_WIDTH-1:0]  he_q;
  logic [$clog2(DEPTH):0] count;
  logic                  err_spurious;

  int n_checks = 0;
  int n_pass   = 0;

  op_t               exp_q[$];
  logic [ADDR_W-1:0] cmp_q[$];

  accel_issue_queue #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .BIT_WIDTH(BIT_WIDTH)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_funct3(cmd_funct3),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst),
    .iq_assert(iq_assert), .funct3(funct3), .source(source), .destination(destination),
    .accel_ready(accel_ready), .accel_done(accel_done),
    .cmp_valid(cmp_valid), .cmp_dst(cmp_dst),
    .he_t(he_t), .he_q(he_q), .count(count), .err_spurious(err_spurious)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic seen;
    #1 reset = 1'b0;
    #3;
    n_checks++;
    if ({iq_assert, funct3, source, destination, cmp_valid, cmp_dst, he_t, he_q, err_spurious} !== '0)
      $display("FAIL reset_outputs: got iq=%b f3=%h src=%h dst=%h cv=%b cd=%h t=%h q=%h err=%b, want all 0",
               iq_assert, funct3, source, destination, cmp_valid, cmp_dst, he_t, he_q, err_spurious);
    else n_pass++;
    n_checks++;
    if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready);
    else n_pass++;
    n_checks++;
    if (count !== '0) $display("FAIL reset_count: got %0d want 0", count);
    else n_pass++;
    tick();
    tick();
    reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (iq_assert !== 1'b0) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) $display("FAIL idle_empty_no_issue: got iq_assert seen=%b want 0", seen);
    else n_pass++;
  endtask

  task automatic test_set_param;
    accel_ready = 1'b0;
    cmd_valid = 1'b1; cmd_funct3 = 3'b111; cmd_src = 32'h5; cmd_dst = 32'hd;
    tick();
    cmd_valid = 1'b0;
    n_checks++;
    if (count !== 3'd1) $display("FAIL setp_queued: got count=%0d want 1", count);
    else n_pass++;
    tick();
    n_checks++;
    if (he_t !== 32'h5 || he_q !== 32'hd)
      $display("FAIL setp_tq: got t=%h q=%h want t=5 q=d", he_t, he_q);
    else n_pass++;
    n_checks++;
    if (iq_assert !== 1'b0) $display("FAIL setp_no_issue: got iq_assert=%b want 0", iq_assert);
    else n_pass++;
    n_checks++;
    if (count !== '0) $display("FAIL setp_drained: got count=%0d want 0", count);
    else n_pass++;
  endtask

  task automatic test_single_op;
    op_t e;
    accel_ready = 1'b1;
    cmd_valid = 1'b1; cmd_funct3 = 3'd1; cmd_src = 32'h10; cmd_dst = 32'h20;
    exp_q.push_back('{f3: 3'd1, src: 32'h10, dst: 32'h20});
    tick();
    cmd_valid = 1'b0;
    n_checks++;
    if (iq_assert !== 1'b0) $display("FAIL single_early_issue: got iq_assert=%b want 0", iq_assert);
    else n_pass++;
    tick();
    n_checks++;
    if (iq_assert !== 1'b1) $display("FAIL single_issue: got iq_assert=%b want 1", iq_assert);
    else n_pass++;
    e = exp_q.pop_front();
    cmp_q.push_back(e.dst);
    n_checks++;
    if ({funct3, source, destination} !== e)
      $display("FAIL single_fields: got f3=%h src=%h dst=%h want f3=%h src=%h dst=%h",
               funct3, source, destination, e.f3, e.src, e.dst);
    else n_pass++;
    tick();
    tick();
    n_checks++;
    if (iq_assert !== 1'b0 || {funct3, source, destination} !== e)
      $display("FAIL single_hold: got iq=%b f3=%h src=%h dst=%h want iq=0 f3=%h src=%h dst=%h",
               iq_assert, funct3, source, destination, e.f3, e.src, e.dst);
    else n_pass++;
    accel_done = 1'b1;
    tick();
    accel_done = 1'b0;
    n_checks++;
    if (cmp_valid !== 1'b1 || cmp_dst !== cmp_q[0])
      $display("FAIL single_cmp: got cv=%b cd=%h want cv=1 cd=%h", cmp_valid, cmp_dst, cmp_q[0]);
    else n_pass++;
    void'(cmp_q.pop_front());
    tick();
    n_checks++;
    if (cmp_valid !== 1'b0 || err_spurious !== 1'b0)
      $display("FAIL single_cmp_pulse: got cv=%b err=%b want cv=0 err=0", cmp_valid, err_spurious);
    else n_pass++;
  endtask

  task automatic test_full;
    op_t e;
    int  k;
    accel_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1'b1; cmd_funct3 = 3'(i + 1);
      cmd_src = 32'h100 + 32'(i); cmd_dst = 32'h200 + 32'(i);
      if (i < DEPTH) exp_q.push_back('{f3: 3'(i + 1), src: 32'h100 + 32'(i), dst: 32'h200 + 32'(i)});
      tick();
    end
    cmd_valid = 1'b0;
    n_checks++;
    if (count !== 3'd4 || cmd_ready !== 1'b0)
      $display("FAIL full_state: got count=%0d ready=%b want count=4 ready=0", count, cmd_ready);
    else n_pass++;
    accel_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      k = 0;
      while (iq_assert !== 1'b1 && k < 10) begin
        tick();
        k++;
      end
      n_checks++;
      if (iq_assert !== 1'b1 || exp_q.size() == 0) begin
        $display("FAIL drain_issue_%0d: got iq_assert=%b after %0d cycles want 1", i, iq_assert, k);
      end else begin
        e = exp_q.pop_front();
        if ({funct3, source, destination, count} !== {e, 3'(DEPTH - 1 - i)})
          $display("FAIL drain_order_%0d: got f3=%h src=%h dst=%h cnt=%0d want f3=%h src=%h dst=%h cnt=%0d",
                   i, funct3, source, destination, count, e.f3, e.src, e.dst, DEPTH - 1 - i);
        else n_pass++;
        cmp_q.push_back(e.dst);
      end
      tick();
      tick();
      n_checks++;
      if (iq_assert !== 1'b0) $display("FAIL drain_one_in_flight_%0d: got iq_assert=%b want 0", i, iq_assert);
      else n_pass++;
      accel_done = 1'b1;
      tick();
      accel_done = 1'b0;
      n_checks++;
      if (cmp_q.size() == 0 || cmp_valid !== 1'b1 || cmp_dst !== cmp_q[0])
        $display("FAIL drain_cmp_%0d: got cv=%b cd=%h want cv=1 cd=%h", i, cmp_valid, cmp_dst,
                 (cmp_q.size() != 0) ? cmp_q[0] : '0);
      else n_pass++;
      if (cmp_q.size() != 0) void'(cmp_q.pop_front());
    end
    k = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (iq_assert !== 1'b0) k++;
    end
    n_checks++;
    if (k != 0 || count !== '0)
      $display("FAIL full_refused_5th: got extra issues=%0d count=%0d want 0 and 0", k, count);
    else n_pass++;
  endtask

  task automatic test_spurious;
    op_t e;
    accel_done = 1'b1;
    tick();
    accel_done = 1'b0;
    n_checks++;
    if (err_spurious !== 1'b1 || cmp_valid !== 1'b0)
      $display("FAIL spurious_flag: got err=%b cv=%b want err=1 cv=0", err_spurious, cmp_valid);
    else n_pass++;
    cmd_valid = 1'b1; cmd_funct3 = 3'd4; cmd_src = 32'h70; cmd_dst = 32'h80;
    exp_q.push_back('{f3: 3'd4, src: 32'h70, dst: 32'h80});
    tick();
    cmd_valid = 1'b0;
    tick();
    e = exp_q.pop_front();
    n_checks++;
    if (iq_assert !== 1'b1 || {funct3, source, destination} !== e)
      $display("FAIL spurious_still_idle: got iq=%b f3=%h src=%h dst=%h want iq=1 f3=%h src=%h dst=%h",
               iq_assert, funct3, source, destination, e.f3, e.src, e.dst);
    else n_pass++;
    accel_done = 1'b1;
    tick();
    accel_done = 1'b0;
    n_checks++;
    if (cmp_valid !== 1'b1 || cmp_dst !== e.dst || err_spurious !== 1'b1)
      $display("FAIL spurious_cmp: got cv=%b cd=%h err=%b want cv=1 cd=%h err=1",
               cmp_valid, cmp_dst, err_spurious, e.dst);
    else n_pass++;
  endtask

  task automatic test_reset_busy;
    op_t e;
    int  k;
    accel_ready = 1'b1;
    cmd_valid = 1'b1; cmd_funct3 = 3'd3; cmd_src = 32'h30; cmd_dst = 32'h40;
    exp_q.push_back('{f3: 3'd3, src: 32'h30, dst: 32'h40});
    tick();
    cmd_funct3 = 3'd5; cmd_src = 32'h31; cmd_dst = 32'h41;
    tick();
    cmd_valid = 1'b0;
    e = exp_q.pop_front();
    n_checks++;
    if (iq_assert !== 1'b1 || {funct3, source, destination} !== e || count !== 3'd1)
      $display("FAIL busy_push_pop: got iq=%b f3=%h src=%h dst=%h cnt=%0d want iq=1 f3=%h src=%h dst=%h cnt=1",
               iq_assert, funct3, source, destination, count, e.f3, e.src, e.dst);
    else n_pass++;
    tick();
    #2 reset = 1'b0;
    exp_q.delete();
    cmp_q.delete();
    #1;
    n_checks++;
    if (count !== '0 || cmd_ready !== 1'b1 || {iq_assert, funct3, source, destination, err_spurious} !== '0)
      $display("FAIL midop_reset: got cnt=%0d ready=%b iq=%b f3=%h src=%h dst=%h err=%b want cnt=0 ready=1 rest 0",
               count, cmd_ready, iq_assert, funct3, source, destination, err_spurious);
    else n_pass++;
    tick();
    reset = 1'b1;
    k = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (cmp_valid !== 1'b0 || iq_assert !== 1'b0) k++;
    end
    n_checks++;
    if (k != 0) $display("FAIL midop_no_cmp: got %0d cycles with cmp_valid/iq_assert, want 0", k);
    else n_pass++;
    cmd_valid = 1'b1; cmd_funct3 = 3'd2; cmd_src = 32'h50; cmd_dst = 32'h60;
    exp_q.push_back('{f3: 3'd2, src: 32'h50, dst: 32'h60});
    tick();
    cmd_valid = 1'b0;
    tick();
    e = exp_q.pop_front();
    n_checks++;
    if (iq_assert !== 1'b1 || {funct3, source, destination} !== e)
      $display("FAIL post_reset_issue: got iq=%b f3=%h src=%h dst=%h want iq=1 f3=%h src=%h dst=%h",
               iq_assert, funct3, source, destination, e.f3, e.src, e.dst);
    else n_pass++;
    accel_done = 1'b1;
    tick();
    accel_done = 1'b0;
    n_checks++;
    if (cmp_valid !== 1'b1 || cmp_dst !== e.dst)
      $display("FAIL post_reset_cmp: got cv=%b cd=%h want cv=1 cd=%h", cmp_valid, cmp_dst, e.dst);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_set_param();
    test_single_op();
    test_full();
    test_spurious();
    test_reset_busy();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
`default_nettype wire
